// File: rtl/half_adder_pkg.sv
// Shared definitions for the half-adder array.
//   HA_WIDTH_DEFAULT / HA_WIDTH_MAX : default and largest supported lane count.
//   ha_ref(a, b)                    : one-lane reference, returns {carry, sum}.
package half_adder_pkg;

  localparam int unsigned HA_WIDTH_DEFAULT = 1;
  localparam int unsigned HA_WIDTH_MAX     = 64;

  function automatic logic [1:0] ha_ref(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane half adder.
//   a, b : operand bits
//   s    : sum   (a ^ b)
//   c    : carry (a & b)
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Bit-parallel half-adder array with combinational and optional registered outputs.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   a, b          : operands, one bit per lane
//   in_valid      : qualifies a/b for the registered path
//   s, c          : combinational sum / carry, independent of clk and reset
//   s_q, c_q      : registered sum / carry, loaded only when in_valid is high
//   out_valid     : registered in_valid, qualifies s_q/c_q
// With REG_OUT = 0 the registered outputs are plain aliases of the combinational ones.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = HA_WIDTH_DEFAULT,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (s[i]),
      .c (c[i])
    );

    // Sampled on the clock so combinational settling never trips it.
    lane_ref_a: assert property (@(posedge clk) {c[i], s[i]} == ha_ref(a[i], b[i]));
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_d, sum_q;
    logic [WIDTH-1:0] carry_d, carry_q;
    logic             valid_q;

    // Hold the last accepted result while in_valid is low.
    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      if (in_valid) begin
        sum_d   = s;
        carry_d = c;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= '0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= in_valid;
      end
    end

    assign s_q       = sum_q;
    assign c_q       = carry_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    assign s_q       = s;
    assign c_q       = c;
    assign out_valid = in_valid;

    // clk and rst_n have no function without the register stage.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: directed literal checks plus randomized and
// exhaustive stimulus compared every cycle against an arithmetic reference model.
module tb_half_adder;

  logic clk = 1'b0;
  logic clk_idle = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // WIDTH=1 instance on a clock that never toggles.
  logic a1, b1, iv1, s1, c1, sq1, cq1, v1;
  // WIDTH=8 and WIDTH=4 registered instances.
  logic [7:0] a8, b8, s8, c8, sq8, cq8;
  logic       iv8, v8;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic       iv4, v4;
  // REG_OUT=0 instance.
  logic an, bn, ivn, sn, cn, sqn, cqn, vn;

  half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk_idle), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
    .s(s1), .c(c1), .s_q(sq1), .c_q(cq1), .out_valid(v1)
  );
  half_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
    .s(s8), .c(c8), .s_q(sq8), .c_q(cq8), .out_valid(v8)
  );
  half_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4),
    .s(s4), .c(c4), .s_q(sq4), .c_q(cq4), .out_valid(v4)
  );
  half_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_nr (
    .clk(clk_idle), .rst_n(rst_n), .a(an), .b(bn), .in_valid(ivn),
    .s(sn), .c(cn), .s_q(sqn), .c_q(cqn), .out_valid(vn)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per lane, {carry,sum} is the 2-bit arithmetic sum of the two operand bits.
  // Result packs carries in [127:64], sums in [63:0].
  function automatic logic [127:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                           input int w);
    logic [63:0] sm, cy;
    logic [1:0]  t;
    sm = '0;
    cy = '0;
    for (int i = 0; i < w; i++) begin
      t     = 2'(a[i]) + 2'(b[i]);
      sm[i] = t[0];
      cy[i] = t[1];
    end
    return {cy, sm};
  endfunction

  // Model: history of accepted results since the last reset; the registered output
  // shows the most recent one (zero if none), valid shows whether the last edge had one.
  logic [127:0] acc8[$];
  logic [127:0] acc4[$];
  logic         exp_v8, exp_v4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc8.delete();
      acc4.delete();
      exp_v8 <= 1'b0;
      exp_v4 <= 1'b0;
    end else begin
      exp_v8 <= iv8;
      exp_v4 <= iv4;
      if (iv8) acc8.push_back(ref_add(64'(a8), 64'(b8), 8));
      if (iv4) acc4.push_back(ref_add(64'(a4), 64'(b4), 4));
    end
  end

  logic [127:0] r8, r4, last8, last4;
  always @(negedge clk) begin
    if (cmp_en) begin
      r8    = ref_add(64'(a8), 64'(b8), 8);
      r4    = ref_add(64'(a4), 64'(b4), 4);
      last8 = (acc8.size() == 0) ? '0 : acc8[acc8.size()-1];
      last4 = (acc4.size() == 0) ? '0 : acc4[acc4.size()-1];
      check("w8_s",   64'(s8),  64'(r8[7:0]));
      check("w8_c",   64'(c8),  64'(r8[71:64]));
      check("w8_s_q", 64'(sq8), 64'(last8[7:0]));
      check("w8_c_q", 64'(cq8), 64'(last8[71:64]));
      check("w8_vld", 64'(v8),  64'(exp_v8));
      check("w4_s",   64'(s4),  64'(r4[3:0]));
      check("w4_c",   64'(c4),  64'(r4[67:64]));
      check("w4_s_q", 64'(sq4), 64'(last4[3:0]));
      check("w4_c_q", 64'(cq4), 64'(last4[67:64]));
      check("w4_vld", 64'(v4),  64'(exp_v4));
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v);
    @(posedge clk);
    #3;
    a8  = a;
    b8  = b;
    iv8 = v;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic v);
    @(posedge clk);
    #3;
    a4  = a;
    b4  = b;
    iv4 = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] tt_sc [4];
  initial begin
    tt_sc[0] = 2'b00; tt_sc[1] = 2'b10; tt_sc[2] = 2'b10; tt_sc[3] = 2'b01;
    a1 = 0; b1 = 0; iv1 = 1; a8 = 0; b8 = 0; iv8 = 0; a4 = 0; b4 = 0; iv4 = 0;
    an = 0; bn = 0; ivn = 0;

    // Combinational truth table with reset held low and no clock on this instance.
    for (int k = 0; k < 4; k++) begin
      {a1, b1} = 2'(k);
      #10;
      check("w1_tt", 64'({s1, c1}), 64'(tt_sc[k]));
    end
    check("w1_rst_s_q", 64'(sq1), 64'd0);
    check("w1_rst_vld", 64'(v1), 64'd0);
    check("w8_rst_s_q", 64'(sq8), 64'd0);
    check("w8_rst_vld", 64'(v8), 64'd0);

    // REG_OUT=0: everything combinational.
    an = 1; bn = 1; ivn = 1;
    #1;
    check("nr_s_q", 64'(sqn), 64'd0);
    check("nr_c_q", 64'(cqn), 64'd1);
    check("nr_vld", 64'(vn), 64'd1);
    for (int k = 0; k < 4; k++) begin
      {an, bn} = 2'(k);
      ivn = k[0];
      #1;
      check("nr_sc_q", 64'({cqn, sqn}), 64'(2'(k[1]) + 2'(k[0])));
      check("nr_vld_k", 64'(vn), 64'(k[0]));
    end

    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Single transaction.
    drive8(8'hF0, 8'h3C, 1'b1);
    #1;
    check("w8_s_imm", 64'(s8), 64'hCC);
    check("w8_c_imm", 64'(c8), 64'h30);
    drive8(8'hF0, 8'h3C, 1'b0);
    #1;
    check("w8_s_q_1", 64'(sq8), 64'hCC);
    check("w8_c_q_1", 64'(cq8), 64'h30);
    check("w8_vld_1", 64'(v8), 64'd1);

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #1;
    check("rst_s_q", 64'(sq8), 64'd0);
    check("rst_c_q", 64'(cq8), 64'd0);
    check("rst_vld", 64'(v8), 64'd0);
    check("rst_s_live", 64'(s8), 64'hCC);
    a8 = 8'hFF; b8 = 8'h00;
    #1;
    check("rst_s_track", 64'(s8), 64'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back, then idle; registered data must hold after valid drops.
    drive8(8'hFF, 8'hFF, 1'b1);
    drive8(8'h00, 8'hFF, 1'b1);
    #1;
    check("b2b_0", 64'({cq8, sq8, v8}), {47'd0, 8'hFF, 8'h00, 1'b1});
    drive8(8'hAA, 8'h55, 1'b1);
    #1;
    check("b2b_1", 64'({cq8, sq8, v8}), {47'd0, 8'h00, 8'hFF, 1'b1});
    drive8(8'h00, 8'h00, 1'b0);
    #1;
    check("b2b_2", 64'({cq8, sq8, v8}), {47'd0, 8'h00, 8'hFF, 1'b1});
    drive8(8'h00, 8'h00, 1'b0);
    #1;
    check("b2b_end", 64'({cq8, sq8, v8}), {47'd0, 8'h00, 8'hFF, 1'b0});

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 200; n++) begin
      drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end
    drive8(8'h00, 8'h00, 1'b0);

    // Exhaustive 4-lane operand space.
    for (int k = 0; k < 256; k++) begin
      drive4(k[7:4], k[3:0], 1'b1);
    end
    drive4(4'h0, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
